spi_slave_stream: RTL and testbench

- Next-generation SPI slave: WIDTH-bit words, any of the four SPI modes, MSB- or LSB-first selectable at run time.
- Streams any number of consecutive words within one chip-select frame.
- Tx side has a one-word holding buffer with a valid/ready handshake; rx side emits one-cycle valid pulses.
- Sits between the board SPI pins and the local register/FIFO logic.

---
 rtl/spi_slave_stream.sv | 162 ++++++++++++++++
 tb/tb_spi_slave_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_stream.sv
// SPI slave with streaming WIDTH-bit words, all four SPI modes, run-time MSB/LSB order and a one-word tx holding buffer.
// Optional: define SPI_SLAVE_STREAM_ECHO_EN to resend the last received word when the tx buffer is empty.
module spi_slave_stream #(
    parameter int WIDTH = 8,
    parameter int SYNC  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsb_first,
    input  logic             select,
    input  logic             mclk,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             start,
    output logic             abort,
    output logic             underrun,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]       state;
    logic [SYNC:0]    sel_q;
    logic [SYNC:0]    mclk_q;
    logic [SYNC-1:0]  mosi_q;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] buf_word;
    logic [WIDTH-1:0] fill_word;
    logic [CW-1:0]    bitcnt;
    logic             buf_full;
    logic             first;
    logic             wordend;

    // Synchronisers plus one extra flop so edges compare the last two stages.
    // NOTE: select stages reset to 1 so a select still high after reset is not seen as a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q  <= '1;
            mclk_q <= '0;
            mosi_q <= '0;
        end else begin
            sel_q  <= {sel_q[SYNC-1:0], select};
            mclk_q <= {mclk_q[SYNC-1:0], mclk};
            mosi_q <= {mosi_q[SYNC-2:0], mosi};
        end
    end

    logic sel_rise, sel_fall, lead_edge, trail_edge, sample_edge, setup_edge, mosi_s, load;

    assign sel_rise    = sel_q[SYNC-1] & ~sel_q[SYNC];
    assign sel_fall    = ~sel_q[SYNC-1] & sel_q[SYNC];
    assign lead_edge   = (mclk_q[SYNC] == cpol) && (mclk_q[SYNC-1] != cpol);
    assign trail_edge  = (mclk_q[SYNC] != cpol) && (mclk_q[SYNC-1] == cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign setup_edge  = cpha ? lead_edge : trail_edge;
    assign mosi_s      = mosi_q[SYNC-1];

    // A word load happens on frame start and on the first setup edge after a completed word.
    assign load = ((state == IDLE) && sel_rise) ||
                  ((state == ACTIVE) && !sel_fall && setup_edge && !(cpha && first) && wordend);

`ifdef SPI_SLAVE_STREAM_ECHO_EN
    assign fill_word = rx_data;
`else
    assign fill_word = '0;
`endif

    assign tx_ready = ~buf_full;
    assign busy     = (state == ACTIVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            miso     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            buf_word <= '0;
            buf_full <= 1'b0;
            bitcnt   <= '0;
            first    <= 1'b0;
            wordend  <= 1'b0;
            rx_valid <= 1'b0;
            start    <= 1'b0;
            abort    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            // NOTE: pulses default low here and are overridden below; later non-blocking writes win.
            rx_valid <= 1'b0;
            start    <= 1'b0;
            abort    <= 1'b0;
            underrun <= 1'b0;

            // A write in the same cycle as a load is kept for the next load.
            if (tx_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_word <= tx_data;
            end else if (load) begin
                buf_full <= 1'b0;
            end

            if (load) begin
                tx_sr    <= buf_full ? buf_word : fill_word;
                underrun <= ~buf_full;
            end

            if (state == ACTIVE)
                miso <= lsb_first ? tx_sr[0] : tx_sr[WIDTH-1];

            case (state)
                IDLE: begin
                    if (sel_rise) begin
                        state   <= ACTIVE;
                        start   <= 1'b1;
                        bitcnt  <= '0;
                        first   <= 1'b1;
                        wordend <= 1'b0;
                    end
                end
                default: begin
                    if (sel_fall) begin
                        state   <= IDLE;
                        abort   <= (bitcnt != '0);
                        bitcnt  <= '0;
                        first   <= 1'b0;
                        wordend <= 1'b0;
                    end else begin
                        if (bitcnt == CW'(WIDTH)) begin
                            rx_data  <= rx_sr;
                            rx_valid <= 1'b1;
                            bitcnt   <= '0;
                            wordend  <= 1'b1;
                        end
                        if (setup_edge) begin
                            if (cpha && first)
                                first <= 1'b0;
                            else if (wordend)
                                wordend <= 1'b0;
                            else
                                tx_sr <= lsb_first ? {1'b0, tx_sr[WIDTH-1:1]}
                                                   : {tx_sr[WIDTH-2:0], 1'b0};
                        end
                        if (sample_edge) begin
                            rx_sr  <= lsb_first ? {mosi_s, rx_sr[WIDTH-1:1]}
                                                : {rx_sr[WIDTH-2:0], mosi_s};
                            bitcnt <= bitcnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_stream.sv
// Self-checking bench for spi_slave_stream: mode table, streaming, underrun, abort and reset sequences.
// Expected rx words go through a scoreboard queue checked whenever rx_valid pulses.
module tb_spi_slave_stream;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic       select = 1'b0, mclk = 1'b0, mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, start, abort, underrun, busy;

    int n_checks = 0, n_errors = 0;
    int n_rx = 0, n_start = 0, n_abort = 0, n_under = 0;
    logic [7:0] rxq[$];

    spi_slave_stream #(.WIDTH(8), .SYNC(2)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .select(select), .mclk(mclk), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .start(start), .abort(abort),
        .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on rx_valid, pulse counters.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                n_rx++;
                if (rxq.size() > 0) begin
                    check("rx_data", rx_data, rxq.pop_front());
                end else begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_spurious: rx_valid with data %0h, none expected", rx_data);
                end
            end
            if (start)    n_start++;
            if (abort)    n_abort++;
            if (underrun) n_under++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] d);
        for (int i = 0; i < 400; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        check("tx_ready_wait", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic frame_begin();
        mclk = cpol;
        repeat (4) @(negedge clk);
        select = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        half();
        select = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Master shifts nbits of mo out and assembles what it samples from miso.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        int idx;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb_first ? i : 7 - i;
            if (!cpha) begin
                mosi = mo[idx];
                half();
                mclk = ~cpol;
                mi[idx] = miso;
                half();
                mclk = cpol;
            end else begin
                half();
                mclk = ~cpol;
                mosi = mo[idx];
                half();
                mclk = cpol;
                mi[idx] = miso;
            end
        end
    endtask

    typedef struct {
        logic       cpol, cpha, lsb;
        logic [7:0] tx, mo;
        logic [7:0] exp_mi, exp_rx;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic [7:0] mi, mi2;
        int s0, r0, u0, a0;

        vecs[0] = '{cpol: 0, cpha: 0, lsb: 0, tx: 8'hA5, mo: 8'h3C, exp_mi: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{cpol: 0, cpha: 1, lsb: 1, tx: 8'h81, mo: 8'h01, exp_mi: 8'h81, exp_rx: 8'h01};
        vecs[2] = '{cpol: 1, cpha: 0, lsb: 1, tx: 8'h81, mo: 8'h01, exp_mi: 8'h81, exp_rx: 8'h01};
        vecs[3] = '{cpol: 1, cpha: 1, lsb: 1, tx: 8'h81, mo: 8'h01, exp_mi: 8'h81, exp_rx: 8'h01};

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_miso", miso, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_tx_ready", tx_ready, 1'b1);
        check("reset_busy", busy, 1'b0);

        // Mode table: one word per frame.
        for (int v = 0; v < 4; v++) begin
            cpol = vecs[v].cpol;
            cpha = vecs[v].cpha;
            lsb_first = vecs[v].lsb;
            mclk = cpol;
            repeat (4) @(negedge clk);
            write_tx(vecs[v].tx);
            s0 = n_start;
            r0 = n_rx;
            frame_begin();
            check($sformatf("v%0d_start", v), n_start - s0, 1);
            check($sformatf("v%0d_busy", v), busy, 1'b1);
            check($sformatf("v%0d_tx_ready_after_load", v), tx_ready, 1'b1);
            rxq.push_back(vecs[v].exp_rx);
            xfer(vecs[v].mo, 8, mi);
            frame_end();
            check($sformatf("v%0d_master_rx", v), mi, vecs[v].exp_mi);
            check($sformatf("v%0d_rx_count", v), n_rx - r0, 1);
            check($sformatf("v%0d_idle", v), busy, 1'b0);
        end

        // Streaming: three words in one frame, mode 3 MSB first.
        cpol = 1; cpha = 1; lsb_first = 0;
        write_tx(8'h11);
        u0 = n_under;
        r0 = n_rx;
        frame_begin();
        fork
            begin
                write_tx(8'h22);
                write_tx(8'h33);
            end
            begin
                rxq.push_back(8'hC1);
                xfer(8'hC1, 8, mi);
                check("stream_w0", mi, 8'h11);
                rxq.push_back(8'h5E);
                xfer(8'h5E, 8, mi);
                check("stream_w1", mi, 8'h22);
                rxq.push_back(8'h7F);
                xfer(8'h7F, 8, mi);
                check("stream_w2", mi, 8'h33);
            end
        join
        frame_end();
        check("stream_rx_count", n_rx - r0, 3);
        check("stream_no_underrun", n_under - u0, 0);

        // Underrun: 16-bit frame in mode 1 with one buffered word.
        cpol = 0; cpha = 1; lsb_first = 0;
        write_tx(8'h5A);
        u0 = n_under;
        frame_begin();
        rxq.push_back(8'h96);
        xfer(8'h96, 8, mi);
        rxq.push_back(8'h3B);
        xfer(8'h3B, 8, mi2);
        frame_end();
        check("underrun_w0", mi, 8'h5A);
`ifdef SPI_SLAVE_STREAM_ECHO_EN
        check("underrun_w1_echo", mi2, 8'h96);
`else
        check("underrun_w1_zero", mi2, 8'h00);
`endif
        check("underrun_pulses", n_under - u0, 1);

        // Abort: deselect after 5 bits, buffered word survives for the next frame.
        cpol = 0; cpha = 0; lsb_first = 0;
        write_tx(8'hC3);
        frame_begin();
        write_tx(8'h96);
        a0 = n_abort;
        r0 = n_rx;
        xfer(8'h55, 5, mi);
        frame_end();
        check("abort_pulse", n_abort - a0, 1);
        check("abort_no_rx", n_rx - r0, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_buffer_kept", tx_ready, 1'b0);
        frame_begin();
        rxq.push_back(8'hE7);
        xfer(8'hE7, 8, mi);
        frame_end();
        check("abort_next_word", mi, 8'h96);

        // Reset mid-word, then no rx until a fresh select rise.
        write_tx(8'h77);
        frame_begin();
        xfer(8'hAA, 3, mi);
        reset = 1'b1;
        @(negedge clk);
        check("rst_miso", miso, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_pulses", {rx_valid, start, abort, underrun}, 4'b0000);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        r0 = n_rx;
        s0 = n_start;
        xfer(8'hAA, 8, mi);
        check("rst_no_rx_without_rise", n_rx - r0, 0);
        check("rst_no_start", n_start - s0, 0);
        frame_end();
        frame_begin();
        rxq.push_back(8'h4D);
        xfer(8'h4D, 8, mi);
        frame_end();
        check("rst_rearm_rx", n_rx - r0, 1);
        check("rst_rearm_master_rx", mi, 8'h00);

        check("scoreboard_drained", rxq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
